// File: rtl/mem_stage.sv
// Memory-access pipeline stage: takes one instruction from EX, runs
// loads/stores over a req/ack data-memory handshake with a hang timeout,
// and registers the MEM/WB fields for the write-back mux.
module mem_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic        ex_memtoreg,
  input  logic        ex_regwrite,
  input  logic [2:0]  ex_rd,
  input  logic [15:0] ex_alu_result,
  input  logic [15:0] ex_store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_memtoreg,
  output logic        wb_regwrite,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_rd_data_mem,
  output logic [15:0] wb_rd_data_alu,
  output logic        dmem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [15:0] dmem_addr_q, dmem_addr_d;
  logic [15:0] dmem_wdata_q, dmem_wdata_d;
  logic        cap_memtoreg_q, cap_memtoreg_d;
  logic        cap_regwrite_q, cap_regwrite_d;
  logic [2:0]  cap_rd_q, cap_rd_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_memtoreg_q, wb_memtoreg_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [2:0]  wb_rd_q, wb_rd_d;
  logic [15:0] wb_mem_q, wb_mem_d;
  logic [15:0] wb_alu_q, wb_alu_d;
  logic        dmem_err_q, dmem_err_d;

  assign cnt_inc = cnt_q + 8'd1;

  // Next-state and next-output decode; every register holds unless changed.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    dmem_req_d     = dmem_req_q;
    dmem_we_d      = dmem_we_q;
    dmem_addr_d    = dmem_addr_q;
    dmem_wdata_d   = dmem_wdata_q;
    cap_memtoreg_d = cap_memtoreg_q;
    cap_regwrite_d = cap_regwrite_q;
    cap_rd_d       = cap_rd_q;
    wb_valid_d     = 1'b0;
    wb_memtoreg_d  = wb_memtoreg_q;
    wb_regwrite_d  = wb_regwrite_q;
    wb_rd_d        = wb_rd_q;
    wb_mem_d       = wb_mem_q;
    wb_alu_d       = wb_alu_q;
    dmem_err_d     = dmem_err_q;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (ex_memread || ex_memwrite) begin
            // Write takes priority when both read and write are set.
            state_d        = ACCESS;
            cnt_d          = 8'd0;
            dmem_req_d     = 1'b1;
            dmem_we_d      = ex_memwrite;
            dmem_addr_d    = ex_alu_result;
            dmem_wdata_d   = ex_store_data;
            cap_memtoreg_d = ex_memtoreg;
            cap_regwrite_d = ex_regwrite;
            cap_rd_d       = ex_rd;
          end else begin
            wb_valid_d    = 1'b1;
            wb_memtoreg_d = ex_memtoreg;
            wb_regwrite_d = ex_regwrite;
            wb_rd_d       = ex_rd;
            wb_alu_d      = ex_alu_result;
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          // Ack wins over a timeout landing on the same edge.
          state_d       = IDLE;
          dmem_req_d    = 1'b0;
          wb_valid_d    = 1'b1;
          wb_memtoreg_d = cap_memtoreg_q;
          wb_regwrite_d = cap_regwrite_q;
          wb_rd_d       = cap_rd_q;
          wb_alu_d      = dmem_addr_q;
          if (!dmem_we_q) begin
            wb_mem_d = dmem_rdata;
          end
        end else if (cnt_inc == TIMEOUT_W) begin
          // Hung access: retire harmlessly and flag the error.
          state_d       = IDLE;
          cnt_d         = cnt_inc;
          dmem_req_d    = 1'b0;
          dmem_err_d    = 1'b1;
          wb_valid_d    = 1'b1;
          wb_memtoreg_d = cap_memtoreg_q;
          wb_regwrite_d = 1'b0;
          wb_rd_d       = cap_rd_q;
          wb_alu_d      = dmem_addr_q;
          wb_mem_d      = 16'h0000;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      dmem_addr_q    <= 16'h0000;
      dmem_wdata_q   <= 16'h0000;
      cap_memtoreg_q <= 1'b0;
      cap_regwrite_q <= 1'b0;
      cap_rd_q       <= 3'd0;
      wb_valid_q     <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_rd_q        <= 3'd0;
      wb_mem_q       <= 16'h0000;
      wb_alu_q       <= 16'h0000;
      dmem_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dmem_req_q     <= dmem_req_d;
      dmem_we_q      <= dmem_we_d;
      dmem_addr_q    <= dmem_addr_d;
      dmem_wdata_q   <= dmem_wdata_d;
      cap_memtoreg_q <= cap_memtoreg_d;
      cap_regwrite_q <= cap_regwrite_d;
      cap_rd_q       <= cap_rd_d;
      wb_valid_q     <= wb_valid_d;
      wb_memtoreg_q  <= wb_memtoreg_d;
      wb_regwrite_q  <= wb_regwrite_d;
      wb_rd_q        <= wb_rd_d;
      wb_mem_q       <= wb_mem_d;
      wb_alu_q       <= wb_alu_d;
      dmem_err_q     <= dmem_err_d;
    end
  end

  assign ex_ready       = (state_q == IDLE);
  assign dmem_req       = dmem_req_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign wb_valid       = wb_valid_q;
  assign wb_memtoreg    = wb_memtoreg_q;
  assign wb_regwrite    = wb_valid_q & wb_regwrite_q;
  assign wb_rd          = wb_rd_q;
  assign wb_rd_data_mem = wb_mem_q;
  assign wb_rd_data_alu = wb_alu_q;
  assign dmem_err       = dmem_err_q;

endmodule
